// File: rtl/lock_pkg.sv
// Shared types and constants for the sequence-lock controller.
package lock_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RESULT,
    UNLOCKED,
    LOCKOUT
  } state_e;

  localparam int         CODE_BYTES = 3;
  localparam int         FAIL_CNT_W = 4;
  localparam logic [7:0] DEF_CODE0  = 8'hAA;
  localparam logic [7:0] DEF_CODE1  = 8'hBB;
  localparam logic [7:0] DEF_CODE2  = 8'hCC;
endpackage

// File: rtl/lock_ctrl_if.sv
// Requester-side bus of the lock controller: submissions in, grant/result/status out.
interface lock_ctrl_if import lock_pkg::*; #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [8*CODE_BYTES*NUM_REQ-1:0] req_code;
  logic                            relock;
  logic [NUM_REQ-1:0]              grant;
  logic                            done;
  logic                            pass;
  logic [ID_W-1:0]                 done_id;
  logic                            unlocked;
  logic                            locked_out;
  logic [FAIL_CNT_W-1:0]           fail_cnt;

  modport master (
    output req_valid, req_code, relock,
    input  grant, done, pass, done_id, unlocked, locked_out, fail_cnt
  );

  modport slave (
    input  req_valid, req_code, relock,
    output grant, done, pass, done_id, unlocked, locked_out, fail_cnt
  );
endinterface

// File: rtl/lock_rr_arbiter.sv
// Round-robin arbiter: combinational pick, pointer advances past the winner only when accepted.
module lock_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       accept,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       any
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] ptr_q, ptr_d;
  int              k;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    k      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt_id = ID_W'(k);
      end
    end
    if (any) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && any)
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/lock_ctrl.sv
// Arbitrated 3-byte code checker with fail counting, lockout and timed auto-relock.
module lock_ctrl import lock_pkg::*; #(
  parameter int         NUM_REQ        = 4,
  parameter logic [7:0] CODE0          = DEF_CODE0,
  parameter logic [7:0] CODE1          = DEF_CODE1,
  parameter logic [7:0] CODE2          = DEF_CODE2,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 16,
  parameter int         UNLOCK_CYCLES  = 32
) (
  input logic        clk,
  input logic        reset_n,
  lock_ctrl_if.slave bus
);
  localparam int         ID_W     = $clog2(NUM_REQ);
  localparam int         CODE_W   = 8 * CODE_BYTES;
  localparam int         TMR_MAX  = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int         TMR_W    = $clog2(TMR_MAX + 1);
  localparam logic [1:0] LAST_IDX = 2'(CODE_BYTES - 1);

  state_e                state_q, state_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [1:0]            idx_q, idx_d;
  logic                  mism_q, mism_d;
  logic [FAIL_CNT_W-1:0] fail_q, fail_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic               arb_accept;
  logic [7:0]         cur_byte, exp_byte;
  logic               fail_last;

  // Gating with reset_n keeps the pointer frozen while reset is held.
  assign arb_accept = reset_n && (state_q == IDLE);
  assign fail_last  = (int'(fail_q) + 1 >= MAX_FAILS);

  lock_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (bus.req_valid),
    .accept (arb_accept),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    case (idx_q)
      2'd0:    begin cur_byte = code_q[7:0];   exp_byte = CODE0; end
      2'd1:    begin cur_byte = code_q[15:8];  exp_byte = CODE1; end
      2'd2:    begin cur_byte = code_q[23:16]; exp_byte = CODE2; end
      default: begin cur_byte = '0;            exp_byte = '0;    end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (arb_any) state_d = CHECK;
      CHECK:    if (idx_q == LAST_IDX) state_d = RESULT;
      RESULT:   state_d = !mism_q ? UNLOCKED : (fail_last ? LOCKOUT : IDLE);
      UNLOCKED: if (bus.relock || tmr_q == '0) state_d = IDLE;
      LOCKOUT:  if (tmr_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // All three bytes are always compared so timing does not leak the mismatch position.
  always_comb begin
    code_d = code_q;
    id_d   = id_q;
    idx_d  = idx_q;
    mism_d = mism_q;
    fail_d = fail_q;
    tmr_d  = tmr_q;
    case (state_q)
      IDLE: if (arb_any) begin
        code_d = bus.req_code[CODE_W*arb_id +: CODE_W];
        id_d   = arb_id;
        idx_d  = '0;
        mism_d = 1'b0;
      end
      CHECK: begin
        mism_d = mism_q | (cur_byte != exp_byte);
        idx_d  = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
      end
      RESULT: begin
        if (!mism_q) begin
          fail_d = '0;
          tmr_d  = TMR_W'(UNLOCK_CYCLES - 1);
        end else if (fail_last) begin
          fail_d = FAIL_CNT_W'(MAX_FAILS);
          tmr_d  = TMR_W'(LOCKOUT_CYCLES - 1);
        end else begin
          fail_d = fail_q + FAIL_CNT_W'(1);
        end
      end
      UNLOCKED: begin
        if (bus.relock)         tmr_d = '0;
        else if (tmr_q != '0)   tmr_d = tmr_q - TMR_W'(1);
      end
      LOCKOUT: begin
        if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
        else             fail_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code_q <= '0;
      id_q   <= '0;
      idx_q  <= '0;
      mism_q <= 1'b0;
      fail_q <= '0;
      tmr_q  <= '0;
    end else begin
      code_q <= code_d;
      id_q   <= id_d;
      idx_q  <= idx_d;
      mism_q <= mism_d;
      fail_q <= fail_d;
      tmr_q  <= tmr_d;
    end
  end

  always_comb begin
    bus.grant      = '0;
    bus.done       = 1'b0;
    bus.pass       = 1'b0;
    bus.done_id    = '0;
    bus.unlocked   = 1'b0;
    bus.locked_out = 1'b0;
    bus.fail_cnt   = '0;
    if (reset_n) begin
      bus.fail_cnt = fail_q;
      case (state_q)
        IDLE:     bus.grant = arb_gnt;
        RESULT: begin
          bus.done    = 1'b1;
          bus.pass    = ~mism_q;
          bus.done_id = id_q;
        end
        UNLOCKED: bus.unlocked   = 1'b1;
        LOCKOUT:  bus.locked_out = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_ctrl.sv
// Scenario bench for lock_ctrl: grants feed a result scoreboard, tasks check timing and status.
module tb_lock_ctrl;
  import lock_pkg::*;

  localparam int          N    = 4;
  localparam logic [23:0] GOOD = 24'hCCBBAA;
  localparam logic [23:0] BAD  = 24'hCCBBAB;

  typedef struct {
    int id;
    bit pass;
    int due;
  } sb_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  logic [23:0] codes [N];
  sb_t         sb [$];
  sb_t         mon_e;
  int          mon_gid;

  lock_ctrl_if #(.NUM_REQ(N)) bus ();
  lock_ctrl_if #(.NUM_REQ(N)) bus15 ();

  lock_ctrl #(.NUM_REQ(N)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  lock_ctrl #(.NUM_REQ(N), .MAX_FAILS(15)) dut15 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus15)
  );

  for (genvar g = 0; g < N; g++) begin : g_code
    assign bus.req_code[24*g +: 24] = codes[g];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every grant predicts a result 4 cycles later.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (|bus.grant) begin
        checks++;
        if (!$onehot(bus.grant)) begin
          errors++;
          $display("FAIL grant_onehot: got %b", bus.grant);
        end
        mon_gid = 0;
        for (int i = 0; i < N; i++) if (bus.grant[i]) mon_gid = i;
        sb.push_back('{id: mon_gid, pass: (codes[mon_gid] == GOOD), due: cyc + 4});
      end
      if (bus.done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: done_id=%0d at cycle %0d, none expected", bus.done_id, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (int'(bus.done_id) != mon_e.id || bus.pass !== mon_e.pass || cyc != mon_e.due) begin
            errors++;
            $display("FAIL sb_result: got id=%0d pass=%b cyc=%0d, expected id=%0d pass=%b cyc=%0d",
                     bus.done_id, bus.pass, cyc, mon_e.id, mon_e.pass, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL sb_missing_done: id=%0d expected at cycle %0d", sb[0].id, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_grant(input int max_cyc, output bit got, output int id, output int at);
    got = 1'b0;
    id  = -1;
    at  = -1;
    for (int n = 0; n < max_cyc && !got; n++) begin
      @(negedge clk);
      if (|bus.grant) begin
        got = 1'b1;
        at  = cyc;
        for (int i = 0; i < N; i++) if (bus.grant[i]) id = i;
      end
    end
  endtask

  task automatic apply_reset();
    tick();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.relock    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    bus.req_valid   = '1;
    bus.relock      = 1'b0;
    bus15.req_valid = '0;
    bus15.relock    = 1'b0;
    bus15.req_code  = {N{BAD}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.grant, bus.done, bus.pass, bus.done_id, bus.unlocked, bus.locked_out, bus.fail_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b done=%b pass=%b id=%0d unl=%b lko=%b fc=%0d, expected all 0",
               bus.grant, bus.done, bus.pass, bus.done_id, bus.unlocked, bus.locked_out, bus.fail_cnt);
    end
    tick();
    bus.req_valid = '0;
    reset_n       = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.grant !== '0 || bus.unlocked !== 1'b0 || bus.fail_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: grant=%b unl=%b fc=%0d, expected 0/0/0", bus.grant, bus.unlocked, bus.fail_cnt);
    end
  endtask

  task automatic test_pass();
    bit got;
    int id, at, n;
    tick();
    codes[0]      = GOOD;
    bus.req_valid = 4'b0001;
    wait_grant(10, got, id, at);
    checks++;
    if (!got || bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL pass_grant: got %b, expected 0001", bus.grant);
    end
    tick();
    bus.req_valid = '0;
    wait_to(at + 4);
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.done_id !== 2'd0) begin
      errors++;
      $display("FAIL pass_done: done=%b pass=%b id=%0d, expected 1/1/0", bus.done, bus.pass, bus.done_id);
    end
    @(negedge clk);
    n = 0;
    while (bus.unlocked === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL pass_unlock_len: got %0d cycles, expected 32", n);
    end
    checks++;
    if (bus.unlocked !== 1'b0 || bus.fail_cnt !== 4'd0) begin
      errors++;
      $display("FAIL pass_relocked: unl=%b fc=%0d, expected 0/0", bus.unlocked, bus.fail_cnt);
    end
  endtask

  task automatic test_fail();
    bit got;
    int id, at;
    tick();
    codes[2]      = BAD;
    bus.req_valid = 4'b0100;
    wait_grant(10, got, id, at);
    checks++;
    if (!got || id != 2) begin
      errors++;
      $display("FAIL fail_grant: got id %0d, expected 2", id);
    end
    tick();
    bus.req_valid = '0;
    codes[2]      = GOOD;  // must be ignored: code was captured at grant
    wait_to(at + 4);
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b0 || bus.done_id !== 2'd2) begin
      errors++;
      $display("FAIL fail_done: done=%b pass=%b id=%0d, expected 1/0/2", bus.done, bus.pass, bus.done_id);
    end
    @(negedge clk);
    checks++;
    if (bus.fail_cnt !== 4'd1 || bus.unlocked !== 1'b0) begin
      errors++;
      $display("FAIL fail_count: fc=%0d unl=%b, expected 1/0", bus.fail_cnt, bus.unlocked);
    end
  endtask

  task automatic test_lockout();
    bit got;
    int id, at, n, gbad;
    apply_reset();
    codes[1] = BAD;
    codes[3] = GOOD;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.req_valid = 4'b0010;
      wait_grant(20, got, id, at);
      checks++;
      if (!got || id != 1) begin
        errors++;
        $display("FAIL lockout_grant%0d: got id %0d, expected 1", k, id);
      end
      tick();
      bus.req_valid = '0;
      wait_to(at + 4);
      tick();
      if (k == 2) bus.req_valid = 4'b1000;
      @(negedge clk);
      checks++;
      if (int'(bus.fail_cnt) != k + 1) begin
        errors++;
        $display("FAIL lockout_fc%0d: got %0d, expected %0d", k, bus.fail_cnt, k + 1);
      end
    end
    n    = 0;
    gbad = 0;
    while (bus.locked_out === 1'b1 && n < 100) begin
      if (bus.grant !== '0) gbad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16 || gbad != 0) begin
      errors++;
      $display("FAIL lockout_len: got %0d cycles with %0d grants, expected 16 with 0", n, gbad);
    end
    checks++;
    if (bus.fail_cnt !== 4'd0 || bus.grant !== 4'b1000) begin
      errors++;
      $display("FAIL lockout_exit: fc=%0d grant=%b, expected 0/1000", bus.fail_cnt, bus.grant);
    end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_relock();
    bit got;
    int id, at;
    apply_reset();
    tick();
    codes[0]      = GOOD;
    codes[1]      = BAD;
    bus.req_valid = 4'b0001;
    wait_grant(10, got, id, at);
    checks++;
    if (!got || id != 0) begin
      errors++;
      $display("FAIL relock_grant: got id %0d, expected 0", id);
    end
    tick();
    bus.req_valid = 4'b0010;
    wait_to(at + 5);
    checks++;
    if (bus.unlocked !== 1'b1) begin
      errors++;
      $display("FAIL relock_open: unl=%b, expected 1", bus.unlocked);
    end
    wait_to(at + 8);
    tick();
    bus.relock = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.unlocked !== 1'b1 || bus.grant !== '0) begin
      errors++;
      $display("FAIL relock_hold: unl=%b grant=%b, expected 1/0000", bus.unlocked, bus.grant);
    end
    tick();
    bus.relock = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.unlocked !== 1'b0 || bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL relock_exit: unl=%b grant=%b, expected 0/0010", bus.unlocked, bus.grant);
    end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    bit got;
    int id, at;
    apply_reset();
    tick();
    codes[0]      = GOOD;
    bus.req_valid = 4'b0001;
    wait_grant(10, got, id, at);
    tick();
    bus.req_valid = 4'b0011;
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.grant, bus.done, bus.pass, bus.done_id, bus.unlocked, bus.locked_out, bus.fail_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: grant=%b done=%b unl=%b lko=%b fc=%0d, expected all 0",
               bus.grant, bus.done, bus.unlocked, bus.locked_out, bus.fail_cnt);
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_regrant: done=%b grant=%b at cycle %0d (orig grant %0d), expected 0/0001",
               bus.done, bus.grant, cyc, at);
    end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int ids [5];
    int ats [5];
    int cnt;
    cnt = 0;
    tick();
    bus15.req_valid = '1;
    for (int n = 0; n < 40 && cnt < 5; n++) begin
      @(negedge clk);
      if (|bus15.grant) begin
        for (int i = 0; i < N; i++) if (bus15.grant[i]) ids[cnt] = i;
        ats[cnt] = cyc;
        cnt++;
      end
    end
    tick();
    bus15.req_valid = '0;
    checks++;
    if (cnt != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, expected 5", cnt);
    end
    for (int i = 0; i < cnt; i++) begin
      checks++;
      if (ids[i] != i % N) begin
        errors++;
        $display("FAIL rr_order%0d: got %0d, expected %0d", i, ids[i], i % N);
      end
      if (i > 0) begin
        checks++;
        if (ats[i] - ats[i-1] != 5) begin
          errors++;
          $display("FAIL rr_spacing%0d: got %0d, expected 5", i, ats[i] - ats[i-1]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) codes[i] = BAD;
    test_reset();
    test_pass();
    test_fail();
    test_lockout();
    test_relock();
    test_reset_mid();
    test_back_to_back();
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
